// File: rtl/riscv16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv16_pkg
// Purpose  : Shared opcodes, ALU-op encodings and control FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package riscv16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    localparam logic [3:0] OP_LW  = 4'b0000;
    localparam logic [3:0] OP_SW  = 4'b0001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;
    localparam logic [3:0] OP_MUL = 4'b1110;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_ADDR = 2'b10;
    localparam logic [1:0] ALU_MUL  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mc_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_unit_if
// Purpose  : Instruction/memory handshake and datapath control bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface mc_control_unit_if #(
    parameter int OPC_W   = 4,
    parameter int ALUOP_W = 2
);
    logic [OPC_W-1:0]   opcode;
    logic               zero;
    logic               mem_ready;
    logic               mem_req;
    logic               mem_we;
    logic               ir_write;
    logic               pc_write;
    logic               reg_write;
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
    logic               busy;
    logic               fault;

    modport slave (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, reg_write, reg_dst,
               alu_src, mem_to_reg, alu_op, busy, fault
    );

    modport master (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, reg_write, reg_dst,
               alu_src, mem_to_reg, alu_op, busy, fault
    );
endinterface
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_timer
// Purpose  : Counts memory wait cycles; expire flags WAIT_MAX reached.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clear_i,
    input  wire logic count_i,
    output logic      expire_o
);
    logic [7:0] count_q;
    logic [7:0] count_d;

    // Saturates at WAIT_MAX; the FSM leaves the wait state on expiry anyway.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_i && !expire_o) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == 8'(WAIT_MAX));
endmodule
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_unit
// Purpose  : Multicycle CPU control FSM. Define MC_CTRL_MUL_EN for 8-cycle MUL.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_unit
    import riscv16_pkg::*;
#(
    parameter int          OPC_W    = 4,
    parameter int          ALUOP_W  = 2,
    parameter int unsigned WAIT_MAX = 15
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mc_control_unit_if.slave  bus
);
    state_e             state_q;
    state_e             state_d;
    logic [OPC_W-1:0]   opc_q;
    logic               w_expire;
    logic               w_wait_st;
    logic               w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_is_mul;
    logic               w_dec_jmp;
    logic               w_mul_done;

    // Any nonzero bit above bit 3 fails every match, which yields R-type.
    function automatic logic f_is(input logic [OPC_W-1:0] opc, input logic [3:0] code);
        return opc == OPC_W'(code);
    endfunction

    assign w_is_lw   = f_is(opc_q, OP_LW);
    assign w_is_sw   = f_is(opc_q, OP_SW);
    assign w_is_beq  = f_is(opc_q, OP_BEQ);
    assign w_is_bne  = f_is(opc_q, OP_BNE);
    assign w_dec_jmp = f_is(bus.opcode, OP_JMP);
    assign w_wait_st = (state_q == ST_FETCH) || (state_q == ST_MEM);

`ifdef MC_CTRL_MUL_EN
    logic [2:0] mul_cnt_q;
    assign w_is_mul   = f_is(opc_q, OP_MUL);
    assign w_mul_done = (mul_cnt_q == 3'd7);
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b1;
`endif

    mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  ((state_d != state_q) || !w_wait_st),
        .count_i  (w_wait_st && !bus.mem_ready),
        .expire_o (w_expire)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ready)  state_d = ST_DECODE;
                else if (w_expire)  state_d = ST_FAULT;
            end
            ST_DECODE: state_d = w_dec_jmp ? ST_FETCH : ST_EXEC;
            ST_EXEC: begin
                if (w_is_lw || w_is_sw)        state_d = ST_MEM;
                else if (w_is_beq || w_is_bne) state_d = ST_FETCH;
                else if (!w_is_mul || w_mul_done) state_d = ST_WB;
            end
            ST_MEM: begin
                if (bus.mem_ready)  state_d = w_is_sw ? ST_FETCH : ST_WB;
                else if (w_expire)  state_d = ST_FAULT;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opc_q     <= '0;
`ifdef MC_CTRL_MUL_EN
            mul_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                opc_q <= bus.opcode;
            end
`ifdef MC_CTRL_MUL_EN
            if (state_q == ST_EXEC && w_is_mul) begin
                mul_cnt_q <= mul_cnt_q + 3'd1;
            end
`endif
        end
    end

    // Outputs decode the registered state, so reset clears them at once.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.alu_src    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_op     = ALUOP_W'(ALU_ADD);
        bus.busy       = (state_q != ST_IDLE);
        bus.fault      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus.mem_req  = 1'b1;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
            end
            ST_DECODE: bus.pc_write = w_dec_jmp;
            ST_EXEC: begin
                if (w_is_lw || w_is_sw) begin
                    bus.alu_src = 1'b1;
                    bus.alu_op  = ALUOP_W'(ALU_ADDR);
                end else if (w_is_beq || w_is_bne) begin
                    bus.alu_op   = ALUOP_W'(ALU_SUB);
                    bus.pc_write = w_is_beq ? bus.zero : !bus.zero;
                end else if (w_is_mul) begin
                    bus.alu_op = ALUOP_W'(ALU_MUL);
                end
            end
            ST_MEM: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = w_is_sw;
            end
            ST_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = w_is_lw;
                bus.reg_dst    = !w_is_lw;
            end
            ST_FAULT: bus.fault = 1'b1;
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_unit
// Purpose  : Directed instruction traces checked cycle-by-cycle against a model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mc_control_unit;
    localparam int unsigned WAIT_MAX = 15;
    localparam logic [3:0] T_LW  = 4'b0000;
    localparam logic [3:0] T_SW  = 4'b0001;
    localparam logic [3:0] T_BEQ = 4'b1011;
    localparam logic [3:0] T_BNE = 4'b1100;
    localparam logic [3:0] T_JMP = 4'b1101;
    localparam logic [3:0] T_MUL = 4'b1110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_control_unit_if #(.OPC_W(4), .ALUOP_W(2)) bus ();

    mc_control_unit #(.OPC_W(4), .ALUOP_W(2), .WAIT_MAX(WAIT_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rdy;
        logic        zero;
        logic [3:0]  opc;
        logic [11:0] exp;
    } cyc_t;

    cyc_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Packing: busy fault req we ir pc rw rd as m2r aop[1:0]
    function automatic logic [11:0] ev(input logic busy, flt, req, we, ir, pc,
                                       rw, rd, as_, m2r, input logic [1:0] aop);
        return {busy, flt, req, we, ir, pc, rw, rd, as_, m2r, aop};
    endfunction

    function automatic logic [11:0] dut_out();
        return {bus.busy, bus.fault, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.alu_op};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic push(input logic rdy, input logic zero, input logic [3:0] opc,
                        input logic [11:0] exp);
        cyc_t c;
        c.rdy = rdy; c.zero = zero; c.opc = opc; c.exp = exp;
        q.push_back(c);
    endtask

    // One instruction: fw fetch waits, mw memory waits, z zero flag in EXEC.
    // The opcode is only valid in DECODE; elsewhere a decoy is driven.
    task automatic gen(input logic [3:0] op, input int fw, input int mw,
                       input logic z, input bit stop_in_mem = 1'b0);
        logic [11:0] mem_v;
        for (int i = 0; i < fw; i++) push(1'b0, ~z, T_JMP, ev(1,0,1,0,0,0,0,0,0,0,2'b00));
        push(1'b1, ~z, T_JMP, ev(1,0,1,0,1,1,0,0,0,0,2'b00));
        push(1'b1, ~z, op, ev(1,0,0,0,0,(op == T_JMP),0,0,0,0,2'b00));
        if (op == T_JMP) return;
        if (op == T_LW || op == T_SW) begin
            push(1'b1, z, T_JMP, ev(1,0,0,0,0,0,0,0,1,0,2'b10));
            mem_v = ev(1,0,1,(op == T_SW),0,0,0,0,0,0,2'b00);
            for (int i = 0; i < mw; i++) push(1'b0, ~z, T_JMP, mem_v);
            if (stop_in_mem) return;
            push(1'b1, ~z, T_JMP, mem_v);
            if (op == T_SW) return;
            push(1'b1, ~z, T_JMP, ev(1,0,0,0,0,0,1,0,0,1,2'b00));
            return;
        end
        if (op == T_BEQ || op == T_BNE) begin
            push(1'b1, z, T_JMP, ev(1,0,0,0,0,(op == T_BEQ) ? z : ~z,0,0,0,0,2'b01));
            return;
        end
`ifdef MC_CTRL_MUL_EN
        if (op == T_MUL) begin
            for (int i = 0; i < 8; i++) push(1'b1, z, T_JMP, ev(1,0,0,0,0,0,0,0,0,0,2'b11));
            push(1'b1, ~z, T_JMP, ev(1,0,0,0,0,0,1,1,0,0,2'b00));
            return;
        end
`endif
        push(1'b1, z, T_JMP, ev(1,0,0,0,0,0,0,0,0,0,2'b00));
        push(1'b1, ~z, T_JMP, ev(1,0,0,0,0,0,1,1,0,0,2'b00));
    endtask

    task automatic run_queue();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            bus.mem_ready = c.rdy;
            bus.zero      = c.zero;
            bus.opcode    = c.opc;
            @(negedge clk);
            check($sformatf("cycle%0d", cyc), dut_out(), c.exp);
            cyc++;
        end
    endtask

    initial begin
        bus.opcode    = 4'h0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", dut_out(), 12'b0);
        #1 rst_n = 1'b1;
        #1 check("idle_after_release", dut_out(), 12'b0);

        gen(4'b0011, 0, 0, 1'b0);
        check("pin_rtype_len", 12'(q.size()), 12'd4);
        check("pin_rtype_wb", q[3].exp, 12'b1000_0011_0000);
        run_queue();

        gen(T_LW, 0, 3, 1'b0);
        check("pin_lw_len", 12'(q.size()), 12'd8);
        check("pin_lw_mem_first", q[3].exp, 12'b1010_0000_0000);
        check("pin_lw_mem_last", q[6].exp, 12'b1010_0000_0000);
        check("pin_lw_wb", q[7].exp, 12'b1000_0010_0100);
        run_queue();

        gen(T_SW, 2, 0, 1'b0);
        gen(T_BEQ, 0, 0, 1'b1);
        gen(T_BEQ, 1, 0, 1'b0);
        gen(T_BNE, 0, 0, 1'b1);
        gen(T_BNE, 0, 0, 1'b0);
        gen(T_JMP, 1, 0, 1'b0);
        gen(T_MUL, 0, 0, 1'b0);
        gen(4'b0111, WAIT_MAX, 0, 1'b0);
        gen(T_LW, 0, WAIT_MAX, 1'b1);
        gen(T_SW, 0, 4, 1'b0, 1'b1);
        run_queue();

        // Reset lands in the middle of an SW memory handshake.
        #1 rst_n = 1'b0;
        #1 check("async_reset_mid_mem", dut_out(), 12'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i <= int'(WAIT_MAX); i++)
            push(1'b0, 1'b0, T_JMP, ev(1,0,1,0,0,0,0,0,0,0,2'b00));
        for (int i = 0; i < 5; i++)
            push(1'b1, 1'b1, T_JMP, ev(1,1,0,0,0,0,0,0,0,0,2'b00));
        run_queue();

        #1 rst_n = 1'b0;
        #1 check("fault_cleared_by_reset", dut_out(), 12'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        gen(4'b0010, 0, 0, 1'b1);
        run_queue();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter OPC_W, default 4, opcode width; opcodes occupy the low 4 bits and upper bits SHALL be zero for a legal opcode.
REQ-002 Parameter ALUOP_W, default 2, width of alu_op.
REQ-003 Parameter WAIT_MAX, default 15, memory wait cycles tolerated before fault (range 1..255).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 opcode  input  OPC_W  instruction opcode, sampled in DECODE.
REQ-007 zero  input  1  ALU zero flag, sampled in EXEC.
REQ-008 mem_ready  input  1  memory handshake completion.
REQ-009 mem_req  output  1  memory request, held until mem_ready.
REQ-010 mem_we  output  1  write qualifier for mem_req (SW data phase only).
REQ-011 ir_write, pc_write  output  1 each  load instruction register / program counter.
REQ-012 reg_write, reg_dst, alu_src, mem_to_reg  output  1 each  datapath controls.
REQ-013 alu_op  output  ALUOP_W  00 add/R-type func, 01 subtract-compare, 10 address add.
REQ-014 busy  output  1  high in every state except IDLE; fault  output  1  sticky error flag.

Function
REQ-015 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT, one-hot or binary encoded.
REQ-016 IDLE SHALL advance to FETCH on the first clock edge after rst_n deasserts.
REQ-017 FETCH: mem_req=1, mem_we=0; on mem_ready, ir_write=1 and pc_write=1 for that cycle, then DECODE.
REQ-018 DECODE: one cycle; JMP (1101) asserts pc_write and returns to FETCH; all other opcodes go to EXEC.
REQ-019 EXEC LW (0000)/SW (0001): alu_src=1, alu_op=10, next MEM.
REQ-020 EXEC BEQ (1011)/BNE (1100): alu_op=01; pc_write=zero for BEQ, ~zero for BNE; next FETCH.
REQ-021 EXEC default (R-type): alu_src=0, alu_op=00, next WB.
REQ-022 MEM: mem_req=1, mem_we=1 only for SW; on mem_ready, SW returns to FETCH and LW goes to WB.
REQ-023 WB: reg_write=1 for one cycle; mem_to_reg=1, reg_dst=0 for LW; mem_to_reg=0, reg_dst=1 for R-type; next FETCH.
REQ-024 Opcode with nonzero bits above bit 3 SHALL be treated as R-type (default behaviour).
REQ-025 A wait counter SHALL clear on entry to FETCH/MEM and increment each cycle mem_ready is low; when it reaches WAIT_MAX with mem_ready still low, the next state SHALL be FAULT.
REQ-026 mem_ready together with counter==WAIT_MAX SHALL complete normally (ready wins).
REQ-027 FAULT: all outputs 0 except fault=1 and busy=1; exit only by reset.
REQ-028 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-029 Every output not named for a state SHALL be 0 in that state; all outputs SHALL be registered-state decodes with no glitch-relevant latch.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, wait counter 0, fault 0, all outputs 0, including mid-handshake.

Configuration
REQ-031 Macro MC_CTRL_MUL_EN: when defined, opcode 1110 SHALL be a multicycle multiply: EXEC holds alu_op=11 (ALUOP_W>=2) for 8 cycles via a 3-bit counter, then WB as R-type; busy stays high throughout.
REQ-032 Without MC_CTRL_MUL_EN, opcode 1110 SHALL be treated as R-type and no multiply counter SHALL exist.

Structure
REQ-033 Opcode constants, alu_op encodings and the state enum SHALL live in shared package riscv16_pkg.
REQ-034 The wait/timeout counter SHALL be a sub-module mem_wait_timer (count, clear, expire).

Verification
REQ-035 Reset release, opcode 0011, mem_ready high every cycle -> FETCH,DECODE,EXEC,WB; reg_write=1 and reg_dst=1 in cycle 4 after FETCH.
REQ-036 LW with mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles, then WB with mem_to_reg=1.
REQ-037 BEQ with zero=1 -> pc_write=1 in EXEC; BNE with zero=1 -> pc_write=0 in EXEC.
REQ-038 mem_ready held low in FETCH, WAIT_MAX=15 -> fault=1 after 16 cycles and stays high until rst_n pulse.
REQ-039 rst_n asserted during MEM of SW -> mem_req and mem_we drop to 0 asynchronously; state IDLE.
REQ-040 MC_CTRL_MUL_EN defined, opcode 1110 -> alu_op=11 for exactly 8 EXEC cycles, then reg_write=1.
